fifo_write_ctrl: RTL

Write-side pointer and flag controller for the dual-clock FIFO; it is the counterpart of the read-side controller. It owns the write pointer in both binary and Gray form and synchronizes the read-domain Gray pointer into the write clock domain. From these it produces a registered full flag, an almost-full flag, a fill count and a sticky overflow flag. It gates the memory write strobe so the storage array is never written when full.

---
 rtl/fifo_write_ctrl_if.sv | 42 ++++
 rtl/fifo_write_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl_if.sv
// Producer-side bundle of the write controller: request/flush in, strobe,
// pointers and flags out. The read-domain Gray pointer rides along as an input.
interface fifo_write_ctrl_if #(
  parameter int PTR_WIDTH = 4
);
  logic                 flush;
  logic                 wr_enable;
  logic [PTR_WIDTH:0]   read_ptr_gray;
  logic                 fifo_wr_enable;
  logic [PTR_WIDTH:0]   write_ptr;
  logic [PTR_WIDTH:0]   write_ptr_gray;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wr_count;
  logic                 overflow;

  modport master (
    output flush,
    output wr_enable,
    output read_ptr_gray,
    input  fifo_wr_enable,
    input  write_ptr,
    input  write_ptr_gray,
    input  full,
    input  almost_full,
    input  wr_count,
    input  overflow
  );

  modport slave (
    input  flush,
    input  wr_enable,
    input  read_ptr_gray,
    output fifo_wr_enable,
    output write_ptr,
    output write_ptr_gray,
    output full,
    output almost_full,
    output wr_count,
    output overflow
  );
endinterface

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/flag controller of a dual-clock FIFO: binary and Gray write
// pointers, read-pointer synchronizer, registered full/almost_full/count and sticky overflow.
module fifo_write_ctrl #(
  parameter int PTR_WIDTH          = 4,
  parameter int ALMOST_FULL_THRESH = 12,
  parameter int SYNC_STAGES        = 2
) (
  input  logic               w_clk,
  input  logic               wreset,
  fifo_write_ctrl_if.slave   bus
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q,  full_d;
  logic          af_q,    af_d;
  logic          ovf_q,   ovf_d;
  logic          wr_accept;

  // Read-pointer synchronizer; only Gray values cross, so at most one bit is in flight.
  always_ff @(posedge w_clk or posedge wreset) begin
    if (wreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.read_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rbin[gi] = ^rq[PTR_WIDTH:gi];
    end
  endgenerate

  assign wr_accept = bus.wr_enable & ~full_q & ~bus.flush;

  always_comb begin
    wbin_d = wbin_q;
    if (bus.flush) begin
      wbin_d = '0;
    end else if (wr_accept) begin
      wbin_d = wbin_q + PW'(1);
    end
    wgray_d = wbin_d ^ (wbin_d >> 1);
  end

  // Flags look at the next write pointer against a stale read pointer, so they can
  // only over-report the fill level; that is what keeps full from ever being late.
  always_comb begin
    full_d  = (wgray_d == {~rq[PTR_WIDTH:PTR_WIDTH-1], rq[PTR_WIDTH-2:0]});
    count_d = wbin_d - rbin;
    af_d    = (count_d >= AF_THRESH);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.flush) begin
      ovf_d = 1'b0;
    end else if (bus.wr_enable && full_q) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge w_clk or posedge wreset) begin
    if (wreset) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      count_q <= count_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.fifo_wr_enable = wr_accept;
  assign bus.write_ptr      = wbin_q;
  assign bus.write_ptr_gray = wgray_q;
  assign bus.wr_count       = count_q;
  assign bus.full           = full_q;
  assign bus.almost_full    = af_q;
  assign bus.overflow       = ovf_q;

endmodule
